i2s_tx_serializer: RTL

Serializes parallel audio/test words into a standard Philips I2S stream (bclk, lrck, sdata) for the KC705 I2S sender. It sits directly downstream of the test-data generator. Once per channel slot it pulls one DATA_WIDTH-bit word with a one-cycle `data_req` strobe, which the upstream stage uses as its advance enable. Left and right slots each consume their own word, and all timing is derived from `clk` by an integer divider.

---
 rtl/i2s_tx_serializer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: fetches one word per channel slot with a data_req
// strobe and shifts it out MSB first, one bclk after the lrck transition.
module i2s_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_req,
    output logic                  frame_start,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  sdata,
    output logic                  underflow
);

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned B_W   = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP_PENDING
    } state_e;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [B_W-1:0]        b_q, b_d;
    logic                  ch_q, ch_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  data_req_q, data_req_d;
    logic                  frame_start_q, frame_start_d;
    logic                  bclk_q, bclk_d;
    logic                  lrck_q, lrck_d;
    logic                  sdata_q, sdata_d;
    logic                  underflow_q, underflow_d;
    logic                  div_wrap, b_wrap;

    // Next-state and output logic
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        b_d           = b_q;
        ch_d          = ch_q;
        shift_d       = shift_q;
        data_req_d    = 1'b0;
        frame_start_d = 1'b0;
        bclk_d        = bclk_q;
        lrck_d        = lrck_q;
        sdata_d       = sdata_q;
        underflow_d   = underflow_q;
        div_wrap      = (div_q == DIV_W'(BCLK_DIV - 1));
        b_wrap        = (b_q == B_W'(SLOT_WIDTH - 1));

        // Capture on the edge that ends the data_req cycle
        if (data_req_q) begin
            shift_d = data_valid ? data_in : '0;
            if (!data_valid) begin
                underflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                div_d   = '0;
                b_d     = '0;
                ch_d    = 1'b0;
                bclk_d  = 1'b0;
                lrck_d  = 1'b0;
                sdata_d = 1'b0;
                if (enable) begin
                    state_d       = ST_RUN;
                    data_req_d    = 1'b1;
                    frame_start_d = 1'b1;
                end
            end
            default: begin
                if (state_q == ST_RUN && !enable) begin
                    state_d = ST_STOP_PENDING;
                end else if (state_q == ST_STOP_PENDING && enable) begin
                    state_d = ST_RUN;
                end

                div_d  = div_wrap ? '0 : div_q + DIV_W'(1);
                bclk_d = (div_d >= DIV_W'(BCLK_DIV / 2));

                if (div_wrap) begin
                    b_d = b_wrap ? '0 : b_q + B_W'(1);
                    if (b_wrap) begin
                        ch_d = ~ch_q;
                    end
                    // A pending stop ends exactly where the next left slot would begin
                    if (b_wrap && ch_q && state_q == ST_STOP_PENDING && !enable) begin
                        state_d = ST_IDLE;
                        div_d   = '0;
                        b_d     = '0;
                        ch_d    = 1'b0;
                        shift_d = '0;
                        bclk_d  = 1'b0;
                        lrck_d  = 1'b0;
                        sdata_d = 1'b0;
                    end else begin
                        lrck_d = ch_d;
                        if (b_d == '0) begin
                            sdata_d       = 1'b0;
                            data_req_d    = 1'b1;
                            frame_start_d = ~ch_d;
                        end else if (b_d <= B_W'(DATA_WIDTH)) begin
                            sdata_d = shift_q[DATA_WIDTH-1];
                            shift_d = shift_q << 1;
                        end else begin
                            sdata_d = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    // State register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            b_q           <= '0;
            ch_q          <= 1'b0;
            shift_q       <= '0;
            data_req_q    <= 1'b0;
            frame_start_q <= 1'b0;
            bclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            sdata_q       <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            b_q           <= b_d;
            ch_q          <= ch_d;
            shift_q       <= shift_d;
            data_req_q    <= data_req_d;
            frame_start_q <= frame_start_d;
            bclk_q        <= bclk_d;
            lrck_q        <= lrck_d;
            sdata_q       <= sdata_d;
            underflow_q   <= underflow_d;
        end
    end

    assign data_req    = data_req_q;
    assign frame_start = frame_start_q;
    assign bclk        = bclk_q;
    assign lrck        = lrck_q;
    assign sdata       = sdata_q;
    assign underflow   = underflow_q;

endmodule
